// File: rtl/axi_sim_mem_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4 simulation memory.
package axi_sim_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

  // Encodings are ordered by severity (OKAY < SLVERR < DECERR).
  function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_sim_mem_if.sv
// AXI4 bus bundle between a bench master and the simulation memory slave.
interface axi_sim_mem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 5
);
  logic                    awvalid, awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    wvalid, wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    arvalid, arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    rvalid, rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );
endinterface

// File: rtl/axi_sim_mem_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts (reserved burst behaves as INCR).
module axi_sim_mem_addr_gen
  import axi_sim_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    aligned   = addr & ~(incr - ADDR_WIDTH'(1));
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = aligned + incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((aligned + incr) & wrap_mask);
      default:     next_addr = aligned + incr;
    endcase
  end
endmodule

// File: rtl/axi_sim_mem.sv
// AXI4 slave memory model with independent single-outstanding read/write FSMs.
// Optional SIM_MEM_TOHOST_EN adds a tohost mailbox at BASE_ADDR+MEM_BYTES-8 (needs DATA_WIDTH >= 64).
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, applying write beats
//   W_RESP | bvalid high, holding the burst's worst response
//   R_IDLE | arready high, waiting for a read address
//   R_WAIT | read latency down-count
//   R_DATA | rvalid high, registered beat on the bus
module axi_sim_mem
  import axi_sim_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    ID_WIDTH   = 5,
  parameter int                    MEM_BYTES  = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
  parameter int                    RD_LATENCY = 2
) (
  input logic          clk,
  input logic          rst,
  axi_sim_mem_if.slave s_axi
`ifdef SIM_MEM_TOHOST_EN
  ,
  output logic         tohost_valid,
  output logic [63:0]  tohost_value
`endif
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int DEPTH  = MEM_BYTES / STRB_W;
  localparam logic [ADDR_WIDTH-MEM_AW-1:0] BASE_HI = BASE_ADDR[ADDR_WIDTH-1:MEM_AW];
  localparam logic [7:0] LAT_INIT = 8'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-MEM_AW-1:0] hi, input logic [2:0] sz);
    if (int'(sz) > LANE_W) return RESP_SLVERR;
    if (hi != BASE_HI)     return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot};

  wr_state_e             wr_state, wr_state_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_next;
  logic [7:0]            wr_len_q, wr_cnt_q;
  logic [2:0]            wr_size_q;
  logic [1:0]            wr_burst_q, wr_beat_resp, bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic                  wr_hs, wr_en;

  axi_sim_mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .addr(wr_addr_q), .len(wr_len_q), .size(wr_size_q), .burst(wr_burst_q), .next_addr(wr_next)
  );

  always_comb begin
    wr_state_nxt   = wr_state;
    s_axi.awready  = 1'b0;
    s_axi.wready   = 1'b0;
    s_axi.bvalid   = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axi.awready = !rst;
        if (s_axi.awvalid && !rst) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = !rst;
        // Whichever comes first, wlast or the awlen beat count, closes the burst.
        if (s_axi.wvalid && (s_axi.wlast || wr_cnt_q == wr_len_q)) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  assign wr_beat_resp = beat_resp(wr_addr_q[ADDR_WIDTH-1:MEM_AW], wr_size_q);
  assign wr_hs        = s_axi.wready && s_axi.wvalid;
  assign wr_en        = wr_hs && (wr_beat_resp == RESP_OKAY);
  assign s_axi.bid    = bid_q;
  assign s_axi.bresp  = bresp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state   <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      if (s_axi.awready && s_axi.awvalid) begin
        bid_q      <= s_axi.awid;
        wr_addr_q  <= s_axi.awaddr;
        wr_len_q   <= s_axi.awlen;
        wr_size_q  <= s_axi.awsize;
        wr_burst_q <= s_axi.awburst;
        wr_cnt_q   <= '0;
        bresp_q    <= RESP_OKAY;
      end
      if (wr_hs) begin
        wr_addr_q <= wr_next;
        wr_cnt_q  <= wr_cnt_q + 8'd1;
        bresp_q   <= worse_resp(bresp_q, wr_beat_resp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[wr_addr_q[MEM_AW-1:LANE_W]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  rd_state_e             rd_state, rd_state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_next, rd_load_addr;
  logic [7:0]            rd_len_q, rd_cnt_q, rd_lat_q, rd_load_len, rd_load_cnt;
  logic [2:0]            rd_size_q, rd_load_size;
  logic [1:0]            rd_burst_q, rd_load_resp, rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rlast_q, rd_load;

  axi_sim_mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .addr(rd_addr_q), .len(rd_len_q), .size(rd_size_q), .burst(rd_burst_q), .next_addr(rd_next)
  );

  always_comb begin
    rd_state_nxt  = rd_state;
    rd_load       = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axi.arready = !rst;
        if (s_axi.arvalid && !rst) begin
          rd_state_nxt = (RD_LATENCY <= 1) ? R_DATA : R_WAIT;
          rd_load      = (RD_LATENCY <= 1);
        end
      end
      R_WAIT: begin
        if (rd_lat_q == 8'd0) begin
          rd_state_nxt = R_DATA;
          rd_load      = 1'b1;
        end
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) begin
          if (rlast_q) rd_state_nxt = R_IDLE;
          else         rd_load      = 1'b1;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // The beat register is refilled from whichever address the next beat uses.
  assign rd_load_addr = (rd_state == R_IDLE) ? s_axi.araddr :
                        (rd_state == R_DATA) ? rd_next : rd_addr_q;
  assign rd_load_size = (rd_state == R_IDLE) ? s_axi.arsize : rd_size_q;
  assign rd_load_len  = (rd_state == R_IDLE) ? s_axi.arlen  : rd_len_q;
  assign rd_load_cnt  = (rd_state == R_DATA) ? rd_cnt_q + 8'd1 : 8'd0;
  assign rd_load_resp = beat_resp(rd_load_addr[ADDR_WIDTH-1:MEM_AW], rd_load_size);

  assign s_axi.rid   = rid_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rlast = rlast_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state   <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_lat_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      if (s_axi.arready && s_axi.arvalid) begin
        rid_q      <= s_axi.arid;
        rd_len_q   <= s_axi.arlen;
        rd_size_q  <= s_axi.arsize;
        rd_burst_q <= s_axi.arburst;
        rd_addr_q  <= s_axi.araddr;
        rd_lat_q   <= LAT_INIT;
      end else if (rd_state == R_WAIT && rd_lat_q != 8'd0) begin
        rd_lat_q <= rd_lat_q - 8'd1;
      end
      if (rd_load) begin
        rd_addr_q <= rd_load_addr;
        rd_cnt_q  <= rd_load_cnt;
        rlast_q   <= (rd_load_cnt == rd_load_len);
        rresp_q   <= rd_load_resp;
        rdata_q   <= (rd_load_resp == RESP_OKAY) ? mem[rd_load_addr[MEM_AW-1:LANE_W]] : '0;
      end
    end
  end

`ifdef SIM_MEM_TOHOST_EN
  localparam logic [ADDR_WIDTH-1:0] TOHOST_ADDR = BASE_ADDR + ADDR_WIDTH'(MEM_BYTES - 8);
  localparam int TH_LANE = (MEM_BYTES - 8) % STRB_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_valid <= 1'b0;
      tohost_value <= '0;
    end else begin
      tohost_valid <= 1'b0;
      if (wr_en && wr_addr_q[ADDR_WIDTH-1:LANE_W] == TOHOST_ADDR[ADDR_WIDTH-1:LANE_W] &&
          (&s_axi.wstrb[TH_LANE +: 8])) begin
        tohost_valid <= 1'b1;
        tohost_value <= s_axi.wdata[TH_LANE*8 +: 64];
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_sim_mem.sv
// Directed bench for axi_sim_mem: single-beat vector table plus burst, wrap, stall and reset sequences.
module tb_axi_sim_mem;
  import axi_sim_mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int TMO    = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sim_mem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .ID_WIDTH(5)) bus ();

`ifdef SIM_MEM_TOHOST_EN
  logic        tohost_valid;
  logic [63:0] tohost_value;
  int          th_cnt = 0;
  always @(negedge clk) if (tohost_valid) th_cnt++;
`endif

  axi_sim_mem #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .ID_WIDTH(5), .MEM_BYTES(65536),
    .BASE_ADDR(64'h8000_0000), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axi(bus)
`ifdef SIM_MEM_TOHOST_EN
    ,
    .tohost_valid(tohost_valid),
    .tohost_value(tohost_value)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [4:0]  last_rid;
  int          first_wait;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles", name, TMO);
  endtask

  task automatic ar_send(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [4:0] id);
    int n;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len;
    bus.arsize = size; bus.arburst = burst; bus.arid = id;
    n = 0;
    while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) tmo_fail("ar handshake");
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_collect(input int nbeats);
    int n;
    bus.rready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      while (!bus.rvalid && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) tmo_fail("r beat");
      if (i == 0) first_wait = n;
      rbuf[i] = bus.rdata; rrsp[i] = bus.rresp; rlst[i] = bus.rlast; last_rid = bus.rid;
      @(negedge clk);
    end
    bus.rready = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [4:0] id, input int nbeats);
    ar_send(addr, len, size, burst, id);
    r_collect(nbeats);
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [4:0] id, input int nbeats,
                           input logic [7:0] strb, input logic last_on_final,
                           output logic [1:0] bresp, output logic [4:0] bid);
    int n;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len;
    bus.awsize = size; bus.awburst = burst; bus.awid = id;
    n = 0;
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) tmo_fail("aw handshake");
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = strb;
      bus.wlast = (i == nbeats - 1) && last_on_final;
      n = 0;
      while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) tmo_fail("w handshake");
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) tmo_fail("b response");
    bresp = bus.bresp; bid = bus.bid;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic        chk_data;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [1:0] br;
    logic [4:0] bi;
    int         w;

    tbl[0] = '{64'h8000_0100, 3'd3, 64'h1111_2222_3333_4444, 8'hFF, RESP_OKAY,   1'b1, 64'h1111_2222_3333_4444};
    tbl[1] = '{64'h8000_0100, 3'd3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, RESP_OKAY,   1'b1, 64'h1111_2222_CCCC_DDDD};
    tbl[2] = '{64'h8000_0100, 3'd3, 64'h5555_5555_5555_5555, 8'h00, RESP_OKAY,   1'b1, 64'h1111_2222_CCCC_DDDD};
    tbl[3] = '{64'h8000_0100, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_SLVERR, 1'b0, 64'h0};
    tbl[4] = '{64'h8000_0100, 3'd3, 64'h0,                   8'h00, RESP_OKAY,   1'b1, 64'h1111_2222_CCCC_DDDD};
    tbl[5] = '{64'h9000_0000, 3'd3, 64'h1234_5678_9ABC_DEF0, 8'hFF, RESP_DECERR, 1'b1, 64'h0};
    tbl[6] = '{64'h8000_FFF0, 3'd3, 64'hDEAD_BEEF_0000_1111, 8'hFF, RESP_OKAY,   1'b1, 64'hDEAD_BEEF_0000_1111};
    tbl[7] = '{64'h8000_FFF0, 3'd3, 64'hEE00_0000_0000_0000, 8'h80, RESP_OKAY,   1'b1, 64'hEEAD_BEEF_0000_1111};
    tbl[8] = '{64'h8001_0000, 3'd3, 64'h0000_0000_0000_0001, 8'hFF, RESP_DECERR, 1'b1, 64'h0};

    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.awlock = 0; bus.awcache = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.rready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst awready", 64'(bus.awready), 64'd0);
    check("rst wready",  64'(bus.wready),  64'd0);
    check("rst arready", 64'(bus.arready), 64'd0);
    check("rst bvalid",  64'(bus.bvalid),  64'd0);
    check("rst rvalid",  64'(bus.rvalid),  64'd0);
    check("rst bid/bresp", 64'({bus.bid, bus.bresp}), 64'd0);
    check("rst rid/rresp/rlast", 64'({bus.rid, bus.rresp, bus.rlast}), 64'd0);
    check("rst rdata", bus.rdata, 64'd0);
`ifdef SIM_MEM_TOHOST_EN
    check("rst tohost_value", tohost_value, 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle awready", 64'(bus.awready), 64'd1);

    // INCR burst write then read back
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    axi_write(64'h8000_0000, 8'd3, 3'd3, BURST_INCR, 5'd9, 4, 8'hFF, 1'b1, br, bi);
    check("incr bresp", 64'(br), 64'(RESP_OKAY));
    check("incr bid", 64'(bi), 64'd9);
    axi_read(64'h8000_0000, 8'd3, 3'd3, BURST_INCR, 5'd10, 4);
    for (int i = 0; i < 4; i++) begin
      check("incr rdata", rbuf[i], 64'(i + 1));
      check("incr rlast", 64'(rlst[i]), 64'(i == 3));
    end
    check("incr rid", 64'(last_rid), 64'd10);

    // WRAP read starting mid-boundary, plus first-beat latency
    axi_read(64'h8000_0018, 8'd3, 3'd3, BURST_WRAP, 5'd2, 4);
    check("rd latency waits", 64'(first_wait), 64'(RD_LAT - 1));
    check("wrap beat0", rbuf[0], 64'd4);
    check("wrap beat1", rbuf[1], 64'd1);
    check("wrap beat2", rbuf[2], 64'd2);
    check("wrap beat3", rbuf[3], 64'd3);
    check("wrap rlast", 64'({rlst[0], rlst[1], rlst[2], rlst[3]}), 64'b0001);

    // rready stall mid-burst
    ar_send(64'h8000_0000, 8'd3, 3'd3, BURST_INCR, 5'd4);
    bus.rready = 1'b1;
    w = 0;
    while (!bus.rvalid && w < TMO) begin @(negedge clk); w++; end
    if (w >= TMO) tmo_fail("stall first beat");
    check("stall beat0", bus.rdata, 64'd1);
    @(negedge clk);
    bus.rready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall rvalid", 64'(bus.rvalid), 64'd1);
      check("stall rdata", bus.rdata, 64'd2);
      check("stall rlast", 64'(bus.rlast), 64'd0);
      @(negedge clk);
    end
    r_collect(3);
    check("post-stall beats", {rbuf[0][15:0], rbuf[1][15:0], rbuf[2][15:0]}, 64'h0002_0003_0004);
    check("post-stall rlast", 64'({rlst[0], rlst[1], rlst[2]}), 64'b001);

    // Reset in the middle of a read burst
    ar_send(64'h8000_0000, 8'd3, 3'd3, BURST_INCR, 5'd7);
    bus.rready = 1'b1;
    w = 0;
    while (!bus.rvalid && w < TMO) begin @(negedge clk); w++; end
    if (w >= TMO) tmo_fail("pre-reset beat");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst rvalid", 64'(bus.rvalid), 64'd0);
    check("midrst arready", 64'(bus.arready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.rready = 1'b0;
    @(negedge clk);
    axi_read(64'h8000_0000, 8'd3, 3'd3, BURST_INCR, 5'd8, 4);
    check("post-rst beat0", rbuf[0], 64'd1);
    check("post-rst beat3", rbuf[3], 64'd4);
    check("post-rst rlast", 64'({rlst[0], rlst[1], rlst[2], rlst[3]}), 64'b0001);

    // Single-beat vector table
    for (int i = 0; i < 9; i++) begin
      wbuf[0] = tbl[i].data;
      axi_write(tbl[i].addr, 8'd0, tbl[i].size, BURST_INCR, 5'(i), 1, tbl[i].strb, 1'b1, br, bi);
      check($sformatf("vec%0d bresp", i), 64'(br), 64'(tbl[i].exp_resp));
      check($sformatf("vec%0d bid", i), 64'(bi), 64'(i));
      axi_read(tbl[i].addr, 8'd0, tbl[i].size, BURST_INCR, 5'(i + 16), 1);
      check($sformatf("vec%0d rresp", i), 64'(rrsp[0]), 64'(tbl[i].exp_resp));
      check($sformatf("vec%0d rlast", i), 64'(rlst[0]), 64'd1);
      check($sformatf("vec%0d rid", i), 64'(last_rid), 64'(i + 16));
      if (tbl[i].chk_data) check($sformatf("vec%0d rdata", i), rbuf[0], tbl[i].exp_rdata);
    end

    // Burst straddling the window base
    wbuf[0] = 64'h77; wbuf[1] = 64'h99;
    axi_write(64'h7FFF_FFF8, 8'd1, 3'd3, BURST_INCR, 5'd3, 2, 8'hFF, 1'b1, br, bi);
    check("straddle bresp", 64'(br), 64'(RESP_DECERR));
    axi_read(64'h7FFF_FFF8, 8'd1, 3'd3, BURST_INCR, 5'd3, 2);
    check("straddle r0 resp", 64'(rrsp[0]), 64'(RESP_DECERR));
    check("straddle r0 data", rbuf[0], 64'd0);
    check("straddle r1 resp", 64'(rrsp[1]), 64'(RESP_OKAY));
    check("straddle r1 data", rbuf[1], 64'h99);

    // Early and missing wlast
    wbuf[0] = 64'h10; wbuf[1] = 64'h20;
    axi_write(64'h8000_0300, 8'd3, 3'd3, BURST_INCR, 5'd5, 2, 8'hFF, 1'b1, br, bi);
    check("early wlast bresp", 64'(br), 64'(RESP_OKAY));
    wbuf[0] = 64'h30;
    axi_write(64'h8000_0400, 8'd0, 3'd3, BURST_INCR, 5'd6, 1, 8'hFF, 1'b0, br, bi);
    check("no wlast bresp", 64'(br), 64'(RESP_OKAY));
    check("no wlast bid", 64'(bi), 64'd6);
    axi_read(64'h8000_0300, 8'd1, 3'd3, BURST_INCR, 5'd1, 2);
    check("early wlast data", {rbuf[0][31:0], rbuf[1][31:0]}, 64'h0000_0010_0000_0020);
    axi_read(64'h8000_0400, 8'd0, 3'd3, BURST_FIXED, 5'd1, 1);
    check("no wlast data", rbuf[0], 64'h30);

`ifdef SIM_MEM_TOHOST_EN
    th_cnt = 0;
    wbuf[0] = 64'h1;
    axi_write(64'h8000_FFF8, 8'd0, 3'd3, BURST_INCR, 5'd0, 1, 8'hFF, 1'b1, br, bi);
    repeat (3) @(negedge clk);
    check("tohost pulse cycles", 64'(th_cnt), 64'd1);
    check("tohost value", tohost_value, 64'h1);
    axi_read(64'h8000_FFF8, 8'd0, 3'd3, BURST_INCR, 5'd0, 1);
    check("tohost in memory", rbuf[0], 64'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
